// File: rtl/vec_dot_accel.sv
// vec_dot_accel: bus slave holding 8-entry A/B operand arrays; computes R[k] = A[2k]*B[2k] + A[2k+1]*B[2k+1] with one multiplier.
// Latency: ack (and resp for reads) one cycle after the request; BUSY 1 cycle and DONE 11 cycles after the START ack.
// Backpressure: none; the request is ignored during the ack cycle, giving at most one transaction every 2 cycles.
module vec_dot_accel #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [3:0]        host_be_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic              host_resp_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              irq_o
);

  // Word index of the CTRL register (byte offset 0x50).
  localparam logic [4:0] IDX_CTRL = 5'd20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_a [8];
  logic [DATA_W-1:0] r_b [8];
  logic [DATA_W-1:0] r_r [4];
  logic [DATA_W-1:0] r_acc;
  logic [2:0]        r_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_start;

  logic              r_ack;
  logic              r_resp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic [4:0]        w_idx;
  logic              w_wr_ctrl;
  logic              w_start_req;
  logic              w_done_clr;
  logic              w_go;
  logic              w_load;
  logic              w_mac;
  logic              w_fin;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_sum;
  logic              w_unused;

  // Merge new write data into an old word, one byte lane per enable bit.
  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [3:0]        lanes
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // A request is taken only when we are not already in its ack cycle.
  assign w_accept = host_req_i & ~r_ack;
  assign w_wr     = w_accept & host_we_i;
  assign w_rd     = w_accept & ~host_we_i;
  assign w_idx    = host_addr_i[6:2];

  // CTRL bits live in byte lane 0, so that lane must be enabled for a command to count.
  assign w_wr_ctrl   = w_wr & (w_idx == IDX_CTRL) & host_be_i[0];
  assign w_start_req = w_wr_ctrl & host_wdata_i[0];
  assign w_done_clr  = w_wr_ctrl & host_wdata_i[1];

  // Address bits outside the decoded window carry no meaning inside the block.
  assign w_unused = ^{host_addr_i[ADDR_W-1:7], host_addr_i[1:0]};

  // Single shared multiplier; product and sum wrap modulo 2^DATA_W.
  assign w_prod = r_a[r_idx] * r_b[r_idx];
  assign w_sum  = r_acc + w_prod;

  // Read mux: operands, results, status; anything unmapped reads as zero.
  always_comb begin
    w_rd_val = '0;
    if (!w_idx[4]) begin
      if (w_idx[3]) begin
        w_rd_val = r_b[w_idx[2:0]];
      end else begin
        w_rd_val = r_a[w_idx[2:0]];
      end
    end else if (w_idx[3:2] == 2'b00) begin
      w_rd_val = r_r[w_idx[1:0]];
    end else if (w_idx == IDX_CTRL) begin
      w_rd_val = {{(DATA_W-2){1'b0}}, r_busy, r_done};
    end
  end

  // Bus response: one-cycle ack, resp only for reads, rdata forced to zero outside resp.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_accept;
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rd_val : '0;
    end
  end

  // Operand writes; discarded while a run is in flight so the operands stay stable.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < 8; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_wr && !r_busy && !w_idx[4]) begin
      if (w_idx[3]) begin
        r_b[w_idx[2:0]] <= be_merge(r_b[w_idx[2:0]], host_wdata_i, host_be_i);
      end else begin
        r_a[w_idx[2:0]] <= be_merge(r_a[w_idx[2:0]], host_wdata_i, host_be_i);
      end
    end
  end

  // Latch a START command for the FSM; a START arriving while busy is dropped.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_start <= 1'b0;
    end else begin
      r_start <= w_start_req & ~r_busy;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_load      = 1'b0;
    w_mac       = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_go        = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_MAC;
      end
      S_MAC: begin
        w_mac = 1'b1;
        if (r_idx == 3'd7) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: clear results at start, then one multiply-accumulate per cycle,
  // committing the accumulator to R on the odd element of each pair.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_idx <= '0;
      r_acc <= '0;
      for (int k = 0; k < 4; k++) begin
        r_r[k] <= '0;
      end
    end else if (w_go) begin
      for (int k = 0; k < 4; k++) begin
        r_r[k] <= '0;
      end
    end else if (w_load) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_mac) begin
      r_idx <= r_idx + 3'd1;
      if (r_idx[0]) begin
        r_r[r_idx[2:1]] <= w_sum;
        r_acc           <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  // Status flags: BUSY spans LOAD..FIN, DONE is set at the end of FIN and cleared by start or host.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_go) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_fin) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
    end else if (w_done_clr) begin
      r_done <= 1'b0;
    end
  end

  assign host_ack_o   = r_ack;
  assign host_resp_o  = r_resp;
  assign host_rdata_o = r_rdata;
  assign irq_o        = r_done;

endmodule

// File: tb/tb_vec_dot_accel.sv
// Directed bench for vec_dot_accel: operand load, timed run, busy protection,
// byte enables / wrap / unmapped, done clear, and reset in the middle of a run.
module tb_vec_dot_accel;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] exp_r [4];
  logic [31:0] v;

  vec_dot_accel #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .host_req_i   (req),
    .host_we_i    (we),
    .host_addr_i  (addr),
    .host_be_i    (be),
    .host_wdata_i (wdata),
    .host_ack_o   (ack),
    .host_resp_o  (resp),
    .host_rdata_o (rdata),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle.
  task automatic bus_xfer(input logic is_wr, input logic [7:0] off, input logic [31:0] d,
                          input logic [3:0] lanes, output logic [31:0] rdv);
    int waited;
    waited = 0;
    req   = 1'b1;
    we    = is_wr;
    addr  = BASE + {24'h0, off};
    be    = lanes;
    wdata = d;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (ack !== 1'b1 && waited < 4);
    chk($sformatf("ack@%02h", off), {31'b0, ack}, 32'd1);
    if (is_wr) chk($sformatf("wr_resp@%02h", off), {31'b0, resp}, 32'd0);
    else       chk($sformatf("rd_resp@%02h", off), {31'b0, resp}, 32'd1);
    rdv   = rdata;
    req   = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    wdata = '0;
    addr  = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, off, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bus_xfer(1'b0, off, '0, 4'h0, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] got;
    rd(off, got);
    chk(tag, got, exp);
  endtask

  task automatic load_ops();
    for (int i = 0; i < 8; i++) begin
      wr(8'(i * 4), va[i]);
      wr(8'(8'h20 + i * 4), vb[i]);
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(8'h50, s);
      n++;
    end while (s[0] !== 1'b1 && n < 20);
    chk(tag, {31'b0, s[0]}, 32'd1);
  endtask

  task automatic chk_results(input string tag);
    for (int k = 0; k < 4; k++) begin
      rd_chk($sformatf("%s_R%0d", tag, k), 8'(8'h40 + k * 4), exp_r[k]);
    end
  endtask

  initial begin
    va = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd7, 32'd6, 32'd5};
    vb = '{32'd7, 32'd5, 32'd3, 32'd1, 32'd4, 32'd6, 32'd8, 32'd10};
    exp_r = '{32'h11, 32'h0D, 32'h4A, 32'h62};
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_resp", {31'b0, resp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    rd_chk("rst_ctrl", 8'h50, 32'd0);
    rd_chk("rst_A3", 8'h0C, 32'd0);
    rd_chk("rst_R2", 8'h48, 32'd0);

    // Basic run with exact timing: reads sample at START ack + 1, 3, 5, 7, 9, 11
    load_ops();
    wr(8'h50, 32'd1);
    for (int n = 0; n < 5; n++) rd_chk($sformatf("busy_t%0d", 2 * n + 1), 8'h50, 32'd2);
    rd_chk("done_t11", 8'h50, 32'd1);
    chk("run1_irq", {31'b0, irq}, 32'd1);
    chk_results("run1");
    rd_chk("run1_ctrl", 8'h50, 32'd1);
    @(negedge clk);
    chk("idle_resp", {31'b0, resp}, 32'd0);
    chk("idle_rdata", rdata, 32'd0);

    // Busy protection; R reads mid-run show the cleared/partial state
    wr(8'h50, 32'd1);
    wr(8'h00, 32'hFF);
    wr(8'h50, 32'd1);
    rd_chk("mid_R0_t5", 8'h40, 32'h11);
    rd_chk("mid_R3_t7", 8'h4C, 32'd0);
    rd_chk("busy2_t9", 8'h50, 32'd2);
    rd_chk("done2_t11", 8'h50, 32'd1);
    chk_results("run2");
    rd_chk("A0_kept", 8'h00, 32'd1);

    // Byte enables, wrap, combined clear+start, unmapped
    wr(8'h00, 32'd0);
    bus_xfer(1'b1, 8'h00, 32'hAABB_CCDD, 4'b0011, v);
    rd_chk("A0_be", 8'h00, 32'h0000_CCDD);
    for (int i = 0; i < 8; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    va[0] = 32'hFFFF_FFFF;
    vb[0] = 32'd2;
    load_ops();
    wr(8'h50, 32'd3);
    rd_chk("clr_start_ctrl", 8'h50, 32'd2);
    wait_done("wrap_done");
    exp_r = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
    chk_results("wrap");
    rd_chk("unmapped_rd", 8'h54, 32'd0);
    wr(8'h54, 32'hFFFF_FFFF);
    rd_chk("unmapped_ctrl", 8'h50, 32'd1);
    rd_chk("unmapped_rd2", 8'h54, 32'd0);
    rd_chk("unmapped_A0", 8'h00, 32'hFFFF_FFFF);

    // DONE clear keeps results
    wr(8'h50, 32'd2);
    rd_chk("clr_ctrl", 8'h50, 32'd0);
    chk("clr_irq", {31'b0, irq}, 32'd0);
    rd_chk("clr_R0", 8'h40, 32'hFFFF_FFFE);

    // Reset during MAC step 4, then a fresh run
    va = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8, 32'd7, 32'd6, 32'd5};
    vb = '{32'd7, 32'd5, 32'd3, 32'd1, 32'd4, 32'd6, 32'd8, 32'd10};
    exp_r = '{32'h11, 32'h0D, 32'h4A, 32'h62};
    load_ops();
    wr(8'h50, 32'd1);
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mrst_irq", {31'b0, irq}, 32'd0);
    chk("mrst_ack", {31'b0, ack}, 32'd0);
    for (int i = 0; i < 20; i++) rd_chk($sformatf("mrst_reg%0d", i), 8'(i * 4), 32'd0);
    rd_chk("mrst_ctrl", 8'h50, 32'd0);
    load_ops();
    wr(8'h50, 32'd1);
    wait_done("run3_done");
    chk_results("run3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
